// File: rtl/mem_bus_pkg.sv
// Shared types and helpers for the memory-bus fabric: address width, I/O tag and
// region decode.
package mem_bus_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned IO_SEL_W = 3;
  localparam logic [1:0]  IO_TAG   = 2'b11;

  typedef enum logic {REG_RAM, REG_IO} region_e;

  typedef enum logic {StIdle, StOwned} bus_state_e;

  // The I/O window is the top quarter just above the RAM address range.
  function automatic logic is_io(input logic [ADDR_W-1:0] addr, input int unsigned ram_aw);
    return 2'(addr >> (ram_aw - 32'd1)) == IO_TAG;
  endfunction

endpackage

// File: rtl/mem_bus_fabric_if.sv
// Master-side bundle of the memory-bus fabric: per-master request, address and
// write data in; grant, read-valid and shared read data out.
interface mem_bus_fabric_if #(
  parameter int unsigned NUM_MASTERS = 2
) ();
  import mem_bus_pkg::*;

  logic [NUM_MASTERS-1:0]        m_req;
  logic [NUM_MASTERS-1:0]        m_lock;
  logic [NUM_MASTERS-1:0]        m_wr;
  logic [ADDR_W*NUM_MASTERS-1:0] m_a;
  logic [8*NUM_MASTERS-1:0]      m_dout;
  logic [NUM_MASTERS-1:0]        m_gnt;
  logic [NUM_MASTERS-1:0]        m_rvalid;
  logic [7:0]                    m_rdata;

  modport master (
    output m_req, m_lock, m_wr, m_a, m_dout,
    input  m_gnt, m_rvalid, m_rdata
  );

  modport slave (
    input  m_req, m_lock, m_wr, m_a, m_dout,
    output m_gnt, m_rvalid, m_rdata
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester above the last owner, wrapping
// modulo N. The pointer itself lives in the parent.
module rr_arbiter #(
  parameter int unsigned N    = 2,
  parameter int unsigned IdxW = 3
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] last_i,
  output logic [N-1:0]    gnt_oh_o,
  output logic [IdxW-1:0] gnt_idx_o
);

  int unsigned  idx;
  logic [N-1:0] cand;

  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    idx       = 0;
    cand      = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx  = (32'(last_i) + k) % N;
      cand = N'(1) << idx;
      if (gnt_oh_o == '0 && (req_i & cand) != '0) begin
        gnt_oh_o  = cand;
        gnt_idx_o = IdxW'(idx);
      end
    end
  end

endmodule

// File: rtl/mem_bus_fabric.sv
// Arbitrates NUM_MASTERS byte masters onto one RAM/I-O bus with tagged 1-cycle read return.
// Define MEM_BUS_PRIO0_EN to give master 0 strict, lock-overriding priority.
module mem_bus_fabric
  import mem_bus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned RAM_ADDR_WIDTH = 17
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  mem_bus_fabric_if.slave           bus,
  output logic                      ram_en,
  output logic                      ram_wr,
  output logic [RAM_ADDR_WIDTH-1:0] ram_a,
  output logic [7:0]                ram_din,
  input  logic [7:0]                ram_dout,
  output logic                      io_en,
  output logic                      io_wr,
  output logic [IO_SEL_W-1:0]       io_sel,
  output logic [7:0]                io_din,
  input  logic [7:0]                io_dout,
  input  logic                      io_full,
  output logic [2:0]                owner
);

  localparam int unsigned IdxW = 3;

  bus_state_e             state_q, state_d;
  logic [IdxW-1:0]        owner_q, owner_d, last_q, last_d, rd_id_q, rd_id_d;
  logic                   rd_pend_q, rd_pend_d;
  region_e                rd_io_q, rd_io_d;
  logic [7:0]             rdata_q, rdata_d;

  logic [NUM_MASTERS-1:0] own_oh, arb_oh;
  logic [IdxW-1:0]        arb_idx, idle_winner;
  logic [ADDR_W-1:0]      a_own;
  logic [7:0]             dout_own, rd_data;
  logic                   req_own, lock_own, wr_own, arb_any;
  logic                   stall, issue, release_own, preempt;
  region_e                region;

  rr_arbiter #(
    .N    (NUM_MASTERS),
    .IdxW (IdxW)
  ) u_arb (
    .req_i     (bus.m_req),
    .last_i    (last_q),
    .gnt_oh_o  (arb_oh),
    .gnt_idx_o (arb_idx)
  );

  assign arb_any = |arb_oh;

`ifdef MEM_BUS_PRIO0_EN
  assign preempt     = (state_q == StOwned) && bus.m_req[0] && (owner_q != '0);
  assign idle_winner = bus.m_req[0] ? '0 : arb_idx;
`else
  assign preempt     = 1'b0;
  assign idle_winner = arb_idx;
`endif

  // Owner's view of the bus and the issue/stall/release decisions.
  always_comb begin
    own_oh      = NUM_MASTERS'(1) << owner_q;
    req_own     = |(bus.m_req & own_oh);
    lock_own    = |(bus.m_lock & own_oh);
    wr_own      = |(bus.m_wr & own_oh);
    a_own       = ADDR_W'(bus.m_a >> (ADDR_W * 32'(owner_q)));
    dout_own    = 8'(bus.m_dout >> (32'd8 * 32'(owner_q)));
    region      = is_io(a_own, RAM_ADDR_WIDTH) ? REG_IO : REG_RAM;
    stall       = (region == REG_IO) && wr_own && io_full;
    issue       = (state_q == StOwned) && req_own && !stall;
    release_own = (state_q == StOwned) && !req_own && !lock_own;
    rd_data     = (rd_io_q == REG_IO) ? io_dout : ram_dout;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= StIdle;
      owner_q   <= '0;
      last_q    <= IdxW'(NUM_MASTERS - 1);
      rd_pend_q <= 1'b0;
      rd_id_q   <= '0;
      rd_io_q   <= REG_RAM;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      rd_pend_q <= rd_pend_d;
      rd_id_q   <= rd_id_d;
      rd_io_q   <= rd_io_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      StIdle: begin
        if (arb_any) begin
          state_d = StOwned;
          owner_d = idle_winner;
        end
      end
      StOwned: begin
        if (preempt) begin
          owner_d = '0;
          last_d  = owner_q;
        end else if (release_own) begin
          state_d = StIdle;
          last_d  = owner_q;
        end
      end
      default: state_d = StIdle;
    endcase
    // The read tag is independent of ownership, so a hand-over never loses a return.
    rd_pend_d = issue && !wr_own;
    rd_id_d   = owner_q;
    rd_io_d   = region;
    rdata_d   = rd_pend_q ? rd_data : rdata_q;
  end

  always_comb begin
    bus.m_gnt    = '0;
    bus.m_rvalid = '0;
    bus.m_rdata  = rdata_q;
    ram_en       = 1'b0;
    ram_wr       = 1'b0;
    ram_a        = '0;
    ram_din      = '0;
    io_en        = 1'b0;
    io_wr        = 1'b0;
    io_sel       = '0;
    io_din       = '0;
    owner        = owner_q;
    if (rst_in) begin
      bus.m_rdata = '0;
      owner       = '0;
    end else begin
      if (issue) begin
        bus.m_gnt = own_oh;
        if (region == REG_IO) begin
          io_en  = 1'b1;
          io_wr  = wr_own;
          io_sel = a_own[IO_SEL_W-1:0];
          io_din = dout_own;
        end else begin
          ram_en  = 1'b1;
          ram_wr  = wr_own;
          ram_a   = a_own[RAM_ADDR_WIDTH-1:0];
          ram_din = dout_own;
        end
      end
      if (rd_pend_q) begin
        bus.m_rvalid = NUM_MASTERS'(1) << rd_id_q;
        bus.m_rdata  = rd_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_fabric.sv
// Directed bench for mem_bus_fabric: table of per-cycle vectors plus hand-written
// stall, preemption/lock and reset sequences.
module tb_mem_bus_fabric;

  localparam int unsigned NM = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ram_en, ram_wr, io_en, io_wr, io_full;
  logic [16:0] ram_a;
  logic [7:0]  ram_din, io_din, io_dout;
  logic [7:0]  ram_dout = 8'h00;
  logic [2:0]  io_sel, owner;

  int n_cmp = 0;
  int n_bad = 0;

  mem_bus_fabric_if #(.NUM_MASTERS(NM)) bus ();

  mem_bus_fabric #(
    .NUM_MASTERS    (NM),
    .RAM_ADDR_WIDTH (17)
  ) dut (
    .clk_in   (clk),
    .rst_in   (rst),
    .bus      (bus),
    .ram_en   (ram_en),
    .ram_wr   (ram_wr),
    .ram_a    (ram_a),
    .ram_din  (ram_din),
    .ram_dout (ram_dout),
    .io_en    (io_en),
    .io_wr    (io_wr),
    .io_sel   (io_sel),
    .io_din   (io_din),
    .io_dout  (io_dout),
    .io_full  (io_full),
    .owner    (owner)
  );

  always #5 clk = ~clk;

  // RAM model: synchronous read, byte = low address byte xor 0xA5.
  always_ff @(posedge clk) begin
    if (ram_en && !ram_wr) ram_dout <= ram_a[7:0] ^ 8'hA5;
  end

  typedef struct {
    logic        rst;
    logic [1:0]  req;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [1:0]  gnt;
    logic        ram;
    logic        io;
    logic [1:0]  rv;
    logic [7:0]  rd;
    logic [2:0]  own;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic r, input logic [1:0] q, input logic [31:0] x0,
                              input logic [31:0] x1, input logic [1:0] g, input logic re,
                              input logic ie, input logic [1:0] v, input logic [7:0] d,
                              input logic [2:0] o);
    vec_t t;
    t.rst = r; t.req = q; t.a0 = x0; t.a1 = x1; t.gnt = g;
    t.ram = re; t.io = ie; t.rv = v; t.rd = d; t.own = o;
    return t;
  endfunction

  task automatic chk(input string what, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", what, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    bus.m_req  = '0;
    bus.m_lock = '0;
    bus.m_wr   = '0;
    bus.m_a    = '0;
    bus.m_dout = '0;
    io_full    = 1'b0;
    io_dout    = 8'h5A;

    vecs[0]  = mk(1'b1, 2'b00, 32'h0, 32'h0,     2'b00, 1'b0, 1'b0, 2'b00, 8'h00, 3'd0);
    vecs[1]  = mk(1'b0, 2'b11, 32'h10, 32'h21,   2'b00, 1'b0, 1'b0, 2'b00, 8'h00, 3'd0);
    vecs[2]  = mk(1'b0, 2'b11, 32'h10, 32'h21,   2'b01, 1'b1, 1'b0, 2'b00, 8'h00, 3'd0);
    vecs[3]  = mk(1'b0, 2'b10, 32'h10, 32'h21,   2'b00, 1'b0, 1'b0, 2'b01, 8'hB5, 3'd0);
    vecs[4]  = mk(1'b0, 2'b10, 32'h10, 32'h21,   2'b00, 1'b0, 1'b0, 2'b00, 8'hB5, 3'd0);
    vecs[5]  = mk(1'b0, 2'b10, 32'h10, 32'h21,   2'b10, 1'b1, 1'b0, 2'b00, 8'hB5, 3'd1);
    vecs[6]  = mk(1'b0, 2'b00, 32'h10, 32'h21,   2'b00, 1'b0, 1'b0, 2'b10, 8'h84, 3'd1);
    vecs[7]  = mk(1'b0, 2'b10, 32'h10, 32'h30000, 2'b00, 1'b0, 1'b0, 2'b00, 8'h84, 3'd1);
    vecs[8]  = mk(1'b0, 2'b10, 32'h10, 32'h30000, 2'b10, 1'b0, 1'b1, 2'b00, 8'h84, 3'd1);
    vecs[9]  = mk(1'b0, 2'b00, 32'h10, 32'h30000, 2'b00, 1'b0, 1'b0, 2'b10, 8'h5A, 3'd1);
    vecs[10] = mk(1'b0, 2'b01, 32'h0, 32'h30000, 2'b00, 1'b0, 1'b0, 2'b00, 8'h5A, 3'd1);
    vecs[11] = mk(1'b0, 2'b01, 32'h0, 32'h30000, 2'b01, 1'b1, 1'b0, 2'b00, 8'h5A, 3'd0);
    vecs[12] = mk(1'b0, 2'b01, 32'h1, 32'h30000, 2'b01, 1'b1, 1'b0, 2'b01, 8'hA5, 3'd0);
    vecs[13] = mk(1'b0, 2'b01, 32'h2, 32'h30000, 2'b01, 1'b1, 1'b0, 2'b01, 8'hA4, 3'd0);
    vecs[14] = mk(1'b0, 2'b01, 32'h3, 32'h30000, 2'b01, 1'b1, 1'b0, 2'b01, 8'hA7, 3'd0);
    vecs[15] = mk(1'b0, 2'b00, 32'h3, 32'h30000, 2'b00, 1'b0, 1'b0, 2'b01, 8'hA6, 3'd0);
    vecs[16] = mk(1'b0, 2'b00, 32'h3, 32'h30000, 2'b00, 1'b0, 1'b0, 2'b00, 8'hA6, 3'd0);

    for (int i = 0; i < NV; i++) begin
      next_cyc();
      rst        = vecs[i].rst;
      bus.m_req  = vecs[i].req;
      bus.m_a    = {vecs[i].a1, vecs[i].a0};
      mid();
      chk($sformatf("vec%0d gnt", i),    32'(bus.m_gnt),    32'(vecs[i].gnt));
      chk($sformatf("vec%0d ram_en", i), 32'(ram_en),       32'(vecs[i].ram));
      chk($sformatf("vec%0d io_en", i),  32'(io_en),        32'(vecs[i].io));
      chk($sformatf("vec%0d rvalid", i), 32'(bus.m_rvalid), 32'(vecs[i].rv));
      chk($sformatf("vec%0d rdata", i),  32'(bus.m_rdata),  32'(vecs[i].rd));
      chk($sformatf("vec%0d owner", i),  32'(owner),        32'(vecs[i].own));
      if (i == 8) chk("vec8 io_sel", 32'(io_sel), 32'd0);
    end

    // I/O write held off by io_full, issues the cycle it falls.
    next_cyc(); rst = 1'b1; bus.m_req = '0;
    next_cyc(); rst = 1'b0; bus.m_req = 2'b10; bus.m_wr = 2'b10;
    bus.m_a = {32'h30000, 32'h0}; bus.m_dout = 16'h7700; io_full = 1'b1;
    mid(); chk("stall idle gnt", 32'(bus.m_gnt), 32'd0);
    for (int k = 0; k < 4; k++) begin
      next_cyc(); mid();
      chk($sformatf("stall%0d gnt", k),   32'(bus.m_gnt), 32'd0);
      chk($sformatf("stall%0d io_en", k), 32'(io_en),     32'd0);
    end
    next_cyc(); io_full = 1'b0; mid();
    chk("wr gnt",    32'(bus.m_gnt), 32'h2);
    chk("wr io_en",  32'(io_en),     32'd1);
    chk("wr io_wr",  32'(io_wr),     32'd1);
    chk("wr io_din", 32'(io_din),    32'h77);
    chk("wr io_sel", 32'(io_sel),    32'd0);
    chk("wr ram_en", 32'(ram_en),    32'd0);
    next_cyc(); bus.m_req = '0; bus.m_wr = '0; mid();
    chk("wr no rvalid", 32'(bus.m_rvalid), 32'd0);

    // Master 1 locked and reading; master 0 asks mid-stream.
    next_cyc(); rst = 1'b1;
    next_cyc(); rst = 1'b0; bus.m_req = 2'b10; bus.m_lock = 2'b10;
    bus.m_a = {32'h5, 32'h8};
    mid(); chk("lk idle gnt", 32'(bus.m_gnt), 32'd0);
    next_cyc(); mid();
    chk("lk gnt1",  32'(bus.m_gnt), 32'h2);
    chk("lk own1",  32'(owner),     32'd1);
    next_cyc(); bus.m_req = 2'b11; mid();
    chk("lk req0 gnt", 32'(bus.m_gnt),    32'h2);
    chk("lk req0 rv",  32'(bus.m_rvalid), 32'h2);
    next_cyc(); mid();
`ifdef MEM_BUS_PRIO0_EN
    chk("pre owner", 32'(owner),        32'd0);
    chk("pre gnt",   32'(bus.m_gnt),    32'h1);
    chk("pre rv",    32'(bus.m_rvalid), 32'h2);
    chk("pre rdata", 32'(bus.m_rdata),  32'hA0);
    next_cyc(); bus.m_req = 2'b01; bus.m_lock = 2'b00; mid();
    chk("pre rv0",    32'(bus.m_rvalid), 32'h1);
    chk("pre rdata0", 32'(bus.m_rdata),  32'hAD);
`else
    chk("hold owner", 32'(owner),        32'd1);
    chk("hold gnt",   32'(bus.m_gnt),    32'h2);
    chk("hold rv",    32'(bus.m_rvalid), 32'h2);
    chk("hold rdata", 32'(bus.m_rdata),  32'hA0);
    next_cyc(); bus.m_req = 2'b01; bus.m_lock = 2'b00; mid();
    chk("rel gnt", 32'(bus.m_gnt),    32'd0);
    chk("rel rv",  32'(bus.m_rvalid), 32'h2);
    next_cyc(); mid();
    chk("arb gnt", 32'(bus.m_gnt), 32'd0);
    next_cyc(); mid();
    chk("m0 gnt",   32'(bus.m_gnt), 32'h1);
    chk("m0 owner", 32'(owner),     32'd0);
`endif

    // Reset right after a RAM read grant drops the pending read.
    next_cyc(); rst = 1'b1; bus.m_req = '0; bus.m_lock = '0;
    next_cyc(); rst = 1'b0; bus.m_req = 2'b01; bus.m_a = {32'h0, 32'h10};
    mid(); chk("rs idle gnt", 32'(bus.m_gnt), 32'd0);
    next_cyc(); mid();
    chk("rs gnt",    32'(bus.m_gnt), 32'h1);
    chk("rs ram_en", 32'(ram_en),    32'd1);
    next_cyc(); rst = 1'b1; mid();
    chk("rs0 rv",     32'(bus.m_rvalid), 32'd0);
    chk("rs0 ram_en", 32'(ram_en),       32'd0);
    next_cyc(); rst = 1'b0; bus.m_req = '0; mid();
    chk("rs1 rv",     32'(bus.m_rvalid), 32'd0);
    chk("rs1 gnt",    32'(bus.m_gnt),    32'd0);
    chk("rs1 ram_en", 32'(ram_en),       32'd0);
    chk("rs1 owner",  32'(owner),        32'd0);
    chk("rs1 rdata",  32'(bus.m_rdata),  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_fabric.md
# mem_bus_fabric

Parametrised successor to the fixed CPU/HCI memory-bus multiplex in the top level. Arbitrates `NUM_MASTERS` byte-wide memory masters onto one shared bus and decodes each access to either the internal RAM or the memory-mapped I/O block. Returns read data one cycle later, tagged to the master that issued the access. Sits between the masters (CPU core, HCI debug port, future DMA) and the `ram`/`hci` instances.

## Interface
Parameters:
- `NUM_MASTERS`, 2: number of bus masters, 2..8; master 0 is the debug/HCI master.
- `RAM_ADDR_WIDTH`, 17: RAM address width; I/O region is `a[RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1] == 2'b11`.

Ports (one clock; reset is synchronous and active-high):
- `clk_in`  in  1  system clock
- `rst_in`  in  1  synchronous active-high reset
- `m_req`  in  NUM_MASTERS  per-master access request
- `m_lock`  in  NUM_MASTERS  keep ownership after the current access
- `m_wr`  in  NUM_MASTERS  1 = write, 0 = read
- `m_a`  in  32*NUM_MASTERS  byte address, master i at bits [32i+31:32i]
- `m_dout`  in  8*NUM_MASTERS  write data
- `m_gnt`  out  NUM_MASTERS  access accepted this cycle
- `m_rvalid`  out  NUM_MASTERS  read data valid for master i
- `m_rdata`  out  8  read data, shared by all masters
- `ram_en`, `ram_wr`  out  1  RAM enable / write
- `ram_a`  out  RAM_ADDR_WIDTH  RAM address
- `ram_din`  out  8  RAM write data
- `ram_dout`  in  8  RAM read data (1-cycle latency)
- `io_en`, `io_wr`  out  1  I/O enable / write
- `io_sel`  out  3  `a[2:0]` of the I/O access
- `io_din`  out  8  I/O write data
- `io_dout`  in  8  I/O read data (1-cycle latency)
- `io_full`  in  1  I/O output buffer full
- `owner`  out  3  current owner index, for LEDs/debug

## Operation
- State: `owner_vld`, `owner`, round-robin pointer `last`, read tag `{rd_pend, rd_id, rd_io}`.
- IDLE (`owner_vld=0`): if any `m_req`, pick the first requester searching upward from `last+1` modulo NUM_MASTERS; load `owner` and set `owner_vld` next cycle.
- OWNED: `issue = m_req[owner] & ~stall`; `m_gnt[owner] = issue`, all other grants 0.
- `stall` = I/O write to the owner's address while `io_full=1`; no enable is driven and the owner holds its request.
- Decode on issue: I/O region asserts `io_en`, otherwise `ram_en`. `ram_wr`, `io_wr`, data, `ram_a = a[RAM_ADDR_WIDTH-1:0]` and `io_sel = a[2:0]` come from the owner. Enables are 0 when not issuing.
- Release: when `m_req[owner]=0` and `m_lock[owner]=0`, clear `owner_vld`, set `last=owner`, and return to IDLE next cycle.
- Read return: issued reads set `rd_pend`, `rd_id=owner`, `rd_io=io region`. Next cycle, `m_rvalid[rd_id]=1` and `m_rdata = rd_io ? io_dout : ram_dout`. Otherwise `m_rdata` holds its last value.
- One access per cycle; back-to-back reads are fully pipelined.

## Timing
- Reset values: all outputs 0, `owner_vld=0`, `rd_pend=0`, `last=NUM_MASTERS-1` so master 0 wins the first arbitration.
- Grant latency is 1 cycle from request in IDLE; 0 cycles for an owner that holds its request.
- Read latency is 1 cycle from grant to `m_rvalid`.
- A read pending when ownership changes is still delivered to `rd_id` (the old owner).
- When `rst_in` is asserted mid-access, the enables and `m_rvalid` are 0 in the next cycle, and any pending read is dropped.
- When several requesters arrive in the same cycle, round-robin order decides.
- A requester that arrives in the cycle an owner releases waits for IDLE arbitration.

## Configuration
- `MEM_BUS_PRIO0_EN`
  - Defined: master 0 is strict priority. While `m_req[0]=1` and the owner is not 0, ownership moves to master 0 in the next cycle, ignoring `m_lock`. Master 0 also wins IDLE arbitration over the pointer. This is the HCI debug-break behaviour.
  - Undefined: pure round-robin with lock honoured for all masters.

## Structure
- Package `mem_bus_pkg`: `ADDR_W=32`, `IO_SEL_W=3`, `IO_TAG=2'b11`, region enum `{REG_RAM, REG_IO}`, and the function `is_io(addr, ram_aw)`.
- Sub-module `rr_arbiter`: request vector plus `last` pointer in, one-hot/index winner out. Combinational; the pointer is held in the parent.

## Test plan
- Reset then `m_req=2'b11`, both reads → master 0 is granted first; after it drops, master 1 is granted; each `m_rvalid` fires 1 cycle after its `m_gnt`.
- Master 1 reads `0x30000` (I/O region), `io_dout=8'h5A` → `io_en=1`, `ram_en=0`, `io_sel=0`; next cycle `m_rvalid[1]=1`, `m_rdata=8'h5A`.
- Master 1 writes `0x30000` with `io_full=1` for 4 cycles → `m_gnt=0` and `io_en=0` for 4 cycles; the write issues in the cycle `io_full` falls.
- Master 1 locked, issuing reads; `m_req[0]` rises → with `MEM_BUS_PRIO0_EN`, `owner=0` next cycle and the in-flight read still returns to master 1; without it, master 0 waits until the lock drops.
- `rst_in` asserted in the cycle after a RAM read grant → no `m_rvalid`; `owner_vld=0` and all outputs 0 next cycle.
- Back-to-back reads of `0x00000..0x00003` by one owner → 4 consecutive `m_rvalid` pulses carrying the RAM bytes in order.
